// File: rtl/ins_cache_if.sv
// ins_cache_if: fetch-side and memory-side signals of the instruction cache.
//   slave  : used by the cache (fetch responder, memory requester)
//   master : used by the environment (fetcher + memory controller)
//   if_en_i/if_pc_i    fetch request pulse and PC
//   if_en_o/if_ins_o   registered response pulse and instruction bits
//   br_flag_i          branch mispredict flush
//   mc_en_o/mc_adr_o   memory read request (held) and word address
//   mc_en_i/mc_dat_i   memory reply pulse and data word
interface ins_cache_if #(
    parameter int ADR_W = 32
);
    logic             if_en_i;
    logic [ADR_W-1:0] if_pc_i;
    logic             if_en_o;
    logic [31:0]      if_ins_o;
    logic             br_flag_i;
    logic             mc_en_o;
    logic [ADR_W-1:0] mc_adr_o;
    logic             mc_en_i;
    logic [31:0]      mc_dat_i;

    modport slave (
        input  if_en_i, if_pc_i, br_flag_i, mc_en_i, mc_dat_i,
        output if_en_o, if_ins_o, mc_en_o, mc_adr_o
    );

    modport master (
        output if_en_i, if_pc_i, br_flag_i, mc_en_i, mc_dat_i,
        input  if_en_o, if_ins_o, mc_en_o, mc_adr_o
    );
endinterface

// File: rtl/ins_cache.sv
// ins_cache: direct-mapped instruction cache, one 32-bit word per line.
// Returns the 32 instruction bits starting at a 2-byte-aligned PC; a 32-bit
// instruction in the upper half of word A also needs the low half of word B=A+1.
// Misses are refilled word by word; a branch flush drops the pending reply.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   en        global ready; 0 freezes all state
//   bus       ins_cache_if.slave (fetch request/response, flush, memory port)
module ins_cache #(
    parameter int ADR_W = 32,
    parameter int IDX_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    ins_cache_if.slave  bus
);
    localparam int TAG_W = ADR_W - IDX_W - 2;
    localparam int LINES = 1 << IDX_W;
    localparam logic [ADR_W-3:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, MISS_LO, MISS_HI, RESP} state_t;

    state_t           state, state_n;
    logic [ADR_W-1:0] pc_q, pc_n;
    logic             drop, drop_n;
    logic             if_en_n, mc_en_n;
    logic [31:0]      if_ins_n;
    logic [ADR_W-1:0] mc_adr_n;

    logic [LINES-1:0] vld;
    logic [31:0]      dat_mem [LINES];
    logic [TAG_W-1:0] tag_mem [LINES];

    logic             we;
    logic [IDX_W-1:0] we_idx;
    logic [TAG_W-1:0] we_tag;

    // In IDLE the lookup uses the incoming PC so a hit answers next edge;
    // otherwise it uses the latched PC of the outstanding request.
    logic [ADR_W-1:0] cur_pc;
    logic [ADR_W-3:0] wa, wb;
    logic [IDX_W-1:0] idx_a, idx_b;
    logic [TAG_W-1:0] tag_a, tag_b;
    logic [31:0]      word_a, word_b;
    logic             hit_a, hit_b, need_b, flush, mc_ack;
    logic             unused_pc0;

    assign cur_pc     = (state == IDLE) ? bus.if_pc_i : pc_q;
    assign wa         = cur_pc[ADR_W-1:2];
    assign wb         = wa + ONE;
    assign idx_a      = wa[IDX_W-1:0];
    assign idx_b      = wb[IDX_W-1:0];
    assign tag_a      = wa[ADR_W-3:IDX_W];
    assign tag_b      = wb[ADR_W-3:IDX_W];
    assign word_a     = dat_mem[idx_a];
    assign word_b     = dat_mem[idx_b];
    assign hit_a      = vld[idx_a] && (tag_mem[idx_a] == tag_a);
    assign hit_b      = vld[idx_b] && (tag_mem[idx_b] == tag_b);
    assign need_b     = cur_pc[1] && (word_a[17:16] == 2'b11);
    assign flush      = bus.br_flag_i;
    assign mc_ack     = bus.mc_en_i && bus.mc_en_o;
    assign unused_pc0 = cur_pc[0];

    // Upper half of A is a full 32-bit instruction only when its low bits are 11.
    function automatic logic [31:0] compose(input logic pc1, input logic [31:0] a,
                                            input logic [31:0] b);
        if (!pc1) return a;
        return {(a[17:16] == 2'b11) ? b[15:0] : 16'h0, a[31:16]};
    endfunction

    always_comb begin
        state_n  = state;
        pc_n     = pc_q;
        drop_n   = drop;
        if_en_n  = 1'b0;
        if_ins_n = bus.if_ins_o;
        mc_en_n  = bus.mc_en_o;
        mc_adr_n = bus.mc_adr_o;
        we       = 1'b0;
        we_idx   = idx_a;
        we_tag   = tag_a;
        case (state)
            IDLE: begin
                if (bus.if_en_i && !flush) begin
                    pc_n = bus.if_pc_i;
                    if (hit_a && (!need_b || hit_b)) begin
                        if_en_n  = 1'b1;
                        if_ins_n = compose(cur_pc[1], word_a, word_b);
                    end else if (!hit_a) begin
                        state_n  = MISS_LO;
                        mc_en_n  = 1'b1;
                        mc_adr_n = {wa, 2'b00};
                    end else begin
                        state_n  = MISS_HI;
                        mc_en_n  = 1'b1;
                        mc_adr_n = {wb, 2'b00};
                    end
                end
            end
            MISS_LO: begin
                if (flush) drop_n = 1'b1;
                if (mc_ack) begin
                    we      = 1'b1;
                    mc_en_n = 1'b0;
                    if (drop || flush) begin
                        state_n = IDLE;
                        drop_n  = 1'b0;
                    end else if (cur_pc[1] && (bus.mc_dat_i[17:16] == 2'b11) && !hit_b) begin
                        // B lives on another line, so this cycle's A write can't hit it.
                        state_n  = MISS_HI;
                        mc_adr_n = {wb, 2'b00};
                    end else begin
                        state_n = RESP;
                    end
                end
            end
            MISS_HI: begin
                if (flush) drop_n = 1'b1;
                we_idx = idx_b;
                we_tag = tag_b;
                if (!bus.mc_en_o) begin
                    // Coming from MISS_LO: request line held low for one cycle first.
                    if (drop || flush) begin
                        state_n = IDLE;
                        drop_n  = 1'b0;
                    end else begin
                        mc_en_n = 1'b1;
                    end
                end else if (mc_ack) begin
                    we      = 1'b1;
                    mc_en_n = 1'b0;
                    if (drop || flush) begin
                        state_n = IDLE;
                        drop_n  = 1'b0;
                    end else begin
                        state_n = RESP;
                    end
                end
            end
            RESP: begin
                if (!flush) begin
                    if_en_n  = 1'b1;
                    if_ins_n = compose(cur_pc[1], word_a, word_b);
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc_q         <= '0;
            drop         <= 1'b0;
            vld          <= '0;
            bus.if_en_o  <= 1'b0;
            bus.if_ins_o <= '0;
            bus.mc_en_o  <= 1'b0;
            bus.mc_adr_o <= '0;
        end else if (en) begin
            state        <= state_n;
            pc_q         <= pc_n;
            drop         <= drop_n;
            bus.if_en_o  <= if_en_n;
            bus.if_ins_o <= if_ins_n;
            bus.mc_en_o  <= mc_en_n;
            bus.mc_adr_o <= mc_adr_n;
            if (we) vld[we_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (en && we) begin
            dat_mem[we_idx] <= bus.mc_dat_i;
            tag_mem[we_idx] <= we_tag;
        end
    end
endmodule

// File: tb/tb_ins_cache.sv
module tb_ins_cache;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;

    always #5 clk = ~clk;

    ins_cache_if #(.ADR_W(32)) bus ();

    ins_cache #(.ADR_W(32), .IDX_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int resp_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_mc[$];
    logic [31:0] mem [512];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Response scoreboard
    always @(negedge clk) begin
        if (bus.if_en_o === 1'b1) begin
            resp_cnt++;
            if (exp_q.size() == 0) chk("unexpected_resp", bus.if_ins_o, 32'hDEAD_BEEF);
            else chk("resp_ins", bus.if_ins_o, exp_q.pop_front());
        end
    end

    // Memory controller model: fixed 5-cycle reply, abandons a request cancelled by reset
    initial begin
        logic [31:0] a;
        bus.mc_en_i  = 1'b0;
        bus.mc_dat_i = '0;
        forever begin
            @(negedge clk);
            if (bus.mc_en_o === 1'b1) begin
                a = bus.mc_adr_o;
                if (exp_mc.size() == 0) chk("unexpected_mc", a, 32'hFFFF_FFFF);
                else chk("mc_adr", a, exp_mc.pop_front());
                repeat (5) @(negedge clk);
                if (bus.mc_en_o === 1'b1) begin
                    chk("mc_adr_stable", bus.mc_adr_o, a);
                    bus.mc_en_i  = 1'b1;
                    bus.mc_dat_i = mem[a[10:2]];
                    @(negedge clk);
                    bus.mc_en_i = 1'b0;
                    chk("mc_gap", {31'd0, bus.mc_en_o}, 32'd0);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one request pulse; returns at the negedge following the accept edge.
    task automatic req(input logic [31:0] pc, input bit want, input logic [31:0] ins);
        if (want) exp_q.push_back(ins);
        bus.if_en_i = 1'b1;
        bus.if_pc_i = pc;
        @(negedge clk);
        bus.if_en_i = 1'b0;
    endtask

    task automatic wait_resp(input int n0);
        int k = 0;
        while (resp_cnt == n0 && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("resp_timeout", {31'd0, resp_cnt != n0}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n0;
        bus.if_en_i   = 1'b0;
        bus.if_pc_i   = '0;
        bus.br_flag_i = 1'b0;
        foreach (mem[i]) mem[i] = '0;
        mem[0]     = 32'h00A0_0093;
        mem[1]     = 32'h0513_4501;
        mem[2]     = 32'hABCD_0067;
        mem[4]     = 32'h1111_1111;
        mem[8]     = 32'h2222_2222;
        mem[9'h100] = 32'h1234_5678;

        idle(3);
        chk("rst_if_en", {31'd0, bus.if_en_o}, 32'd0);
        chk("rst_if_ins", bus.if_ins_o, 32'd0);
        chk("rst_mc_en", {31'd0, bus.mc_en_o}, 32'd0);
        chk("rst_mc_adr", bus.mc_adr_o, 32'd0);
        rst = 1'b0;
        idle(2);

        // Cold miss
        exp_mc.push_back(32'h0);
        n0 = resp_cnt;
        req(32'h0, 1, 32'h00A0_0093);
        chk("cold_no_hit", {31'd0, bus.if_en_o}, 32'd0);
        chk("cold_mc_en", {31'd0, bus.mc_en_o}, 32'd1);
        wait_resp(n0);
        idle(10);
        chk("cold_mc_drained", exp_mc.size(), 32'd0);

        // Hit after fill
        n0 = resp_cnt;
        req(32'h0, 1, 32'h00A0_0093);
        chk("hit_lat", {31'd0, bus.if_en_o}, 32'd1);
        chk("hit_no_mc", {31'd0, bus.mc_en_o}, 32'd0);
        wait_resp(n0);
        idle(5);

        // Straddle: two refills, then the same PC hits
        exp_mc.push_back(32'h4);
        exp_mc.push_back(32'h8);
        n0 = resp_cnt;
        req(32'h6, 1, 32'h0067_0513);
        wait_resp(n0);
        idle(10);
        chk("straddle_mc_drained", exp_mc.size(), 32'd0);
        n0 = resp_cnt;
        req(32'h6, 1, 32'h0067_0513);
        chk("straddle_hit_lat", {31'd0, bus.if_en_o}, 32'd1);
        chk("straddle_hit_no_mc", {31'd0, bus.mc_en_o}, 32'd0);
        wait_resp(n0);
        idle(3);

        // en=0 ignores a request
        en = 1'b0;
        bus.if_en_i = 1'b1;
        bus.if_pc_i = 32'h0;
        @(negedge clk);
        bus.if_en_i = 1'b0;
        idle(2);
        chk("freeze_no_resp", {31'd0, bus.if_en_o}, 32'd0);
        chk("freeze_no_mc", {31'd0, bus.mc_en_o}, 32'd0);
        en = 1'b1;
        idle(3);

        // Flush beats a same-cycle hit request
        n0 = resp_cnt;
        bus.br_flag_i = 1'b1;
        bus.if_en_i   = 1'b1;
        bus.if_pc_i   = 32'h0;
        @(negedge clk);
        bus.br_flag_i = 1'b0;
        bus.if_en_i   = 1'b0;
        chk("flush_same_cycle", {31'd0, bus.if_en_o}, 32'd0);
        idle(3);
        chk("flush_same_cycle_cnt", resp_cnt, n0);

        // Conflict eviction on idx 0, then pc 0x2 misses again (compressed upper half)
        exp_mc.push_back(32'h400);
        n0 = resp_cnt;
        req(32'h400, 1, 32'h1234_5678);
        wait_resp(n0);
        idle(2);
        mem[0] = 32'h4505_0001;
        exp_mc.push_back(32'h0);
        n0 = resp_cnt;
        req(32'h2, 1, 32'h0000_4505);
        chk("conflict_miss", {31'd0, bus.mc_en_o}, 32'd1);
        wait_resp(n0);
        idle(10);
        chk("conflict_mc_drained", exp_mc.size(), 32'd0);

        // Flush during MISS_LO: refill completes, no response, then a hit
        exp_mc.push_back(32'h10);
        n0 = resp_cnt;
        req(32'h10, 0, 32'h0);
        @(negedge clk);
        bus.br_flag_i = 1'b1;
        @(negedge clk);
        bus.br_flag_i = 1'b0;
        idle(15);
        chk("flush_mc_drained", exp_mc.size(), 32'd0);
        chk("flush_no_resp", resp_cnt, n0);
        req(32'h10, 1, 32'h1111_1111);
        chk("flush_then_hit", {31'd0, bus.if_en_o}, 32'd1);
        chk("flush_hit_no_mc", {31'd0, bus.mc_en_o}, 32'd0);
        wait_resp(n0);
        idle(3);

        // Reset in the middle of MISS_LO
        exp_mc.push_back(32'h20);
        n0 = resp_cnt;
        req(32'h20, 0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_if_en", {31'd0, bus.if_en_o}, 32'd0);
        chk("midrst_if_ins", bus.if_ins_o, 32'd0);
        chk("midrst_mc_en", {31'd0, bus.mc_en_o}, 32'd0);
        chk("midrst_mc_adr", bus.mc_adr_o, 32'd0);
        rst = 1'b0;
        idle(10);
        chk("midrst_no_resp", resp_cnt, n0);
        exp_mc.push_back(32'h0);
        req(32'h0, 1, 32'h4505_0001);
        chk("post_rst_miss", {31'd0, bus.mc_en_o}, 32'd1);
        wait_resp(n0);
        idle(10);
        chk("post_rst_mc_drained", exp_mc.size(), 32'd0);
        chk("resp_all_consumed", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
